noc_cmd_parser: RTL and testbench
=================================

// Module: noc_cmd_parser
// PURPOSE
//  Front stage of the perm switch. Parses the raw NOC command stream (noc_to_dev_ctl/data) into
//  complete, validated frames and buffers them. Each frame is emitted with its perm port index over
//  a valid/ready stream, only once the whole frame has been received. Frames that are malformed,
//  truncated, misaddressed or do not fit are dropped whole, so the switch only ever sees full frames.
// PARAMETERS
//  DEPTH      256   data buffer entries (9-bit {ctl,data}); power of 2, >= 139 (largest frame)
//  FRAMES     8     committed-frame descriptor queue depth; power of 2
//  PERM_BASE  8'h40 device ID of perm port 0
//  NUM_PORTS  4     perm ports; IDs PERM_BASE..PERM_BASE+NUM_PORTS-1
// PORTS
//  clk              in   1  clock; all flops on posedge
//  reset_n          in   1  asynchronous, active-low reset
//  noc_to_dev_ctl   in   1  NOC control bit; 1 = header/idle byte
//  noc_to_dev_data  in   8  NOC data byte
//  out_valid        out  1  out_word holds a buffered frame word
//  out_ready        in   1  consumer accepts out_word this cycle
//  out_word         out  9  {ctl,data}; ctl=1 on the header word only
//  out_port         out  2  perm port index; stable from sop to eop
//  out_sop          out  1  out_word is the frame header
//  out_eop          out  1  out_word is the last byte of the frame
//  drop_pulse       out  1  one-cycle pulse per dropped frame
// BEHAVIOUR
//  Frame: hdr(ctl=1: [7:6] A code, [5:3] D code, [2:0] op), then ctl=0 bytes: dest, src, A addr, D data.
//   A=1<<[7:6], D=1<<[5:3]. op 3'b010 write: len=A+D+3. op 3'b001 read: len=A+3. ctl=1,data=0 is idle.
//  Input FSM: IDLE -> (valid hdr) DEST -> BODY -> IDLE; counter loaded with len-1 at hdr, decrements per byte.
//   Hdr write is speculative at wr_ptr. commit_ptr advances to wr_ptr+1 on the edge that stores the last byte,
//   and the 2-bit port index is pushed to the descriptor queue on the same edge.
//  Drop (rewind wr_ptr to commit_ptr, drop_pulse=1 next cycle, FSM -> IDLE or DEST for a new hdr):
//   - hdr op not 001/010: bytes discarded until the next nonzero ctl=1 byte
//   - dest outside PERM_BASE..+NUM_PORTS-1
//   - at hdr: free entries (DEPTH-(wr_ptr-rd_ptr)) < len, or descriptor queue full
//   - new nonzero ctl=1 byte while count != 0: current frame dropped, new hdr processed this cycle
//   - ctl=1,data=0 mid-frame: dropped (truncation)
//  Output: registered stage; first word of a frame valid the cycle after its commit edge (min 2 cycles
//   after the last input byte). Word transfers when out_valid&&out_ready; out_* held stable while
//   out_valid&&!out_ready. Back-to-back frames: eop of one and sop of the next on consecutive cycles.
//   Descriptor popped on the eop transfer.
//  Input has no backpressure; space is reserved at hdr time, so the buffer never overflows mid-frame.
//  Pointers are log2(DEPTH)+1 bits; wrap is modulo DEPTH; full/empty from the MSB compare.
//  Reset (any time, incl. mid-frame): pointers, counter, descriptor queue cleared; FSM IDLE;
//   out_valid=0, out_sop=0, out_eop=0, out_word=9'h100, out_port=0, drop_pulse=0. Partial frames are lost.
// CONFIGURATION
//  NOC_CMD_PARSER_STATS_EN defined: adds outputs frame_cnt[15:0] (committed frames) and drop_cnt[15:0]
//   (dropped frames). Both saturate at 16'hFFFF and reset to 0.
//  Not defined: those ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package noc_sw_pkg: opcode constants (OP_RD=3'b001, OP_WR=3'b010), PERM_BASE default,
//   function frame_len(hdr) returning 8-bit len, typedef parser_state_e {IDLE,DEST,BODY,SKIP}.
//  Sub-module rewind_fifo: sync 9-bit FIFO with push, pop, commit and rewind inputs; reads only
//   committed data. The descriptor queue is an inline small FIFO.
// TESTING
//  1 Write hdr 8'h0A (A=1,D=2,op 010), dest 41, src 10, addr 00, data AA BB -> 6 words, sop on 0A,
//    eop on BB, out_port=1.
//  2 Read hdr 8'h41 (A=2,op 001), dest 43 -> 5 words, out_port=3. out_ready low 3 cycles mid-frame
//    -> words held, none lost or duplicated.
//  3 Dest 8'h50 -> no output, one drop_pulse. The next valid frame is emitted intact.
//  4 Hdr op 3'b111 -> its bytes are ignored, drop_pulse once. A following valid frame passes.
//  5 Write frame cut by a new hdr after 3 bytes -> first frame dropped, second emitted complete.
//  6 Nine valid frames with out_ready=0 and FRAMES=8 -> 8 committed, 9th dropped. Release
//    out_ready -> 8 frames in order. Assert reset_n=0 mid-output -> out_valid=0 next sample,
//    all queues empty.

Source files
------------

// File: rtl/noc_sw_pkg.sv
// noc_sw_pkg: shared types and helpers for the perm switch front end.
// Opcodes, default perm base ID, parser states and frame length decode.
package noc_sw_pkg;

    localparam logic [2:0] OP_RD = 3'b001;
    localparam logic [2:0] OP_WR = 3'b010;

    localparam logic [7:0] DEF_PERM_BASE = 8'h40;

    typedef enum logic [1:0] {
        IDLE,
        DEST,
        BODY,
        SKIP
    } parser_state_e;

    // Total frame bytes including the header, from the header byte.
    function automatic logic [7:0] frame_len(input logic [7:0] hdr);
        logic [7:0] a;
        logic [7:0] d;
        a = 8'd1 << hdr[7:6];
        d = 8'd1 << hdr[5:3];
        if (hdr[2:0] == OP_WR) begin
            return a + d + 8'd3;
        end
        return a + 8'd3;
    endfunction

endpackage

// File: rtl/rewind_fifo.sv
// rewind_fifo: 9-bit FIFO whose writes stay speculative until committed.
// Ports: i_push/i_wdata write at wr_ptr (or at commit_ptr when i_rewind),
//   i_commit with i_push makes everything up to this word readable,
//   i_rewind discards uncommitted words, i_pop/o_rdata read committed
//   data, o_empty = nothing committed, o_free = DEPTH - (commit - rd).
module rewind_fifo #(
    parameter int DEPTH = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_push,
    input  logic [8:0]              i_wdata,
    input  logic                    i_commit,
    input  logic                    i_rewind,
    input  logic                    i_pop,
    output logic [8:0]              o_rdata,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_free
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [8:0]  r_mem [DEPTH];
    logic [AW:0] r_wr;
    logic [AW:0] r_cm;
    logic [AW:0] r_rd;
    logic [AW:0] w_wbase;

    // A rewind and a new push in one cycle: the new word lands at commit_ptr.
    assign w_wbase = i_rewind ? r_cm : r_wr;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[w_wbase[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr <= '0;
            r_cm <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) begin
                r_wr <= w_wbase + ONE;
            end else if (i_rewind) begin
                r_wr <= r_cm;
            end
            if (i_push && i_commit) begin
                r_cm <= w_wbase + ONE;
            end
            if (i_pop) begin
                r_rd <= r_rd + ONE;
            end
        end
    end

    assign o_rdata = r_mem[r_rd[AW-1:0]];
    assign o_empty = (r_rd == r_cm);
    assign o_free  = (AW+1)'(DEPTH) - (r_cm - r_rd);

endmodule

// File: rtl/noc_cmd_parser.sv
// noc_cmd_parser: parses the NOC command stream into whole validated frames,
// buffers them and replays each one with its perm port index.
// Ports: clk, reset_n (async, active low); noc_to_dev_ctl/noc_to_dev_data
//   raw input bytes; out_valid/out_ready/out_word/out_port/out_sop/out_eop
//   frame output stream; drop_pulse one cycle per dropped frame.
// NOC_CMD_PARSER_STATS_EN adds frame_cnt/drop_cnt saturating counters.
module noc_cmd_parser import noc_sw_pkg::*; #(
    parameter int         DEPTH     = 256,
    parameter int         FRAMES    = 8,
    parameter logic [7:0] PERM_BASE = DEF_PERM_BASE,
    parameter int         NUM_PORTS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        noc_to_dev_ctl,
    input  logic [7:0]  noc_to_dev_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [8:0]  out_word,
    output logic [1:0]  out_port,
    output logic        out_sop,
    output logic        out_eop,
    output logic        drop_pulse
`ifdef NOC_CMD_PARSER_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FRAMES);

    parser_state_e r_state;
    parser_state_e w_state_nxt;
    logic [7:0]    r_cnt;
    logic [7:0]    w_cnt_nxt;
    logic [1:0]    r_port;
    logic [1:0]    w_port_nxt;
    logic          r_drop;

    logic          w_push;
    logic          w_commit;
    logic          w_rewind;
    logic          w_drop;
    logic          w_hdr;
    logic          w_in_frame;
    logic          w_op_ok;
    logic          w_room;
    logic          w_dest_ok;
    logic [1:0]    w_dest_idx;
    logic [7:0]    w_len;
    logic [AW:0]   w_free;
    logic [8:0]    w_rdata;
    logic          w_empty;
    logic          w_load;

    logic [1:0]    r_desc [FRAMES];
    logic [FW:0]   r_dwr;
    logic [FW:0]   r_drd;
    logic [FW:0]   w_drd_nx;
    logic          w_dfull;
    logic          w_dpop;
    logic [1:0]    w_head_port;
    logic [7:0]    r_orem;
    logic [7:0]    w_olen;

    assign w_hdr      = noc_to_dev_ctl && (noc_to_dev_data != 8'h00);
    assign w_in_frame = (r_state == DEST) || (r_state == BODY);
    assign w_op_ok    = (noc_to_dev_data[2:0] == OP_RD) ||
                        (noc_to_dev_data[2:0] == OP_WR);
    assign w_len      = frame_len(noc_to_dev_data);
    // Free space is measured from commit_ptr so a frame being cut by this
    // header does not count against the new one.
    assign w_room     = (w_free >= (AW+1)'(w_len)) && !w_dfull;
    assign w_dest_ok  = ({1'b0, noc_to_dev_data} >= {1'b0, PERM_BASE}) &&
                        ({1'b0, noc_to_dev_data} <
                         {1'b0, PERM_BASE} + 9'(NUM_PORTS));
    assign w_dest_idx = noc_to_dev_data[1:0] - PERM_BASE[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_port  <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_port  <= w_port_nxt;
            r_drop  <= w_drop;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_port_nxt  = r_port;
        w_push      = 1'b0;
        w_commit    = 1'b0;
        w_rewind    = 1'b0;
        w_drop      = 1'b0;
        // Any ctl=1 byte inside a frame kills it: truncation or a cut.
        if (w_in_frame && noc_to_dev_ctl) begin
            w_rewind    = 1'b1;
            w_drop      = 1'b1;
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end
        if (w_hdr) begin
            if (!w_op_ok) begin
                w_drop      = 1'b1;
                w_state_nxt = SKIP;
            end else if (!w_room) begin
                w_drop      = 1'b1;
                w_state_nxt = IDLE;
            end else begin
                w_push      = 1'b1;
                w_cnt_nxt   = w_len - 8'd1;
                w_state_nxt = DEST;
            end
        end else if (!noc_to_dev_ctl) begin
            case (r_state)
                DEST: begin
                    if (w_dest_ok) begin
                        w_push      = 1'b1;
                        w_cnt_nxt   = r_cnt - 8'd1;
                        w_port_nxt  = w_dest_idx;
                        w_state_nxt = BODY;
                    end else begin
                        w_rewind    = 1'b1;
                        w_drop      = 1'b1;
                        w_state_nxt = SKIP;
                    end
                end
                BODY: begin
                    w_push = 1'b1;
                    if (r_cnt == 8'd1) begin
                        w_commit    = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    rewind_fifo #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_push   (w_push),
        .i_wdata  ({noc_to_dev_ctl, noc_to_dev_data}),
        .i_commit (w_commit),
        .i_rewind (w_rewind),
        .i_pop    (w_load),
        .o_rdata  (w_rdata),
        .o_empty  (w_empty),
        .o_free   (w_free)
    );

    assign w_dfull  = (r_dwr[FW] != r_drd[FW]) &&
                      (r_dwr[FW-1:0] == r_drd[FW-1:0]);
    assign w_dpop   = out_valid && out_ready && out_eop;
    assign w_drd_nx = r_drd + (FW+1)'(1);
    // A sop loaded on the eop transfer edge belongs to the next descriptor.
    assign w_head_port = w_dpop ? r_desc[w_drd_nx[FW-1:0]] :
                                  r_desc[r_drd[FW-1:0]];

    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_desc[r_dwr[FW-1:0]] <= r_port;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dwr <= '0;
            r_drd <= '0;
        end else begin
            if (w_commit) begin
                r_dwr <= r_dwr + (FW+1)'(1);
            end
            if (w_dpop) begin
                r_drd <= w_drd_nx;
            end
        end
    end

    assign w_load = (!out_valid || out_ready) && !w_empty;
    assign w_olen = frame_len(w_rdata[7:0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_word  <= 9'h100;
            out_port  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            r_orem    <= '0;
        end else if (w_load) begin
            out_valid <= 1'b1;
            out_word  <= w_rdata;
            out_sop   <= w_rdata[8];
            if (w_rdata[8]) begin
                out_port <= w_head_port;
                out_eop  <= 1'b0;
                r_orem   <= w_olen - 8'd1;
            end else begin
                out_eop <= (r_orem == 8'd1);
                r_orem  <= r_orem - 8'd1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end
    end

    assign drop_pulse = r_drop;

`ifdef NOC_CMD_PARSER_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_commit && (r_frame_cnt != 16'hFFFF)) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_noc_cmd_parser.sv
// tb_noc_cmd_parser: directed frames into noc_cmd_parser, checks output
// stream words/ports/framing, drop pulses, backpressure and reset.
module tb_noc_cmd_parser;

    logic        clk;
    logic        reset_n;
    logic        ctl;
    logic [7:0]  data;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_word;
    logic [1:0]  out_port;
    logic        out_sop;
    logic        out_eop;
    logic        drop_pulse;
`ifdef NOC_CMD_PARSER_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
`endif

    int n_tests;
    int n_fail;
    int n_drop;
    int d0;

    // {port, sop, eop, word}
    logic [12:0] got[$];
    logic [12:0] exp_q[$];
    logic [8:0]  cur[$];

    noc_cmd_parser dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .noc_to_dev_ctl  (ctl),
        .noc_to_dev_data (data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_word        (out_word),
        .out_port        (out_port),
        .out_sop         (out_sop),
        .out_eop         (out_eop),
        .drop_pulse      (drop_pulse)
`ifdef NOC_CMD_PARSER_STATS_EN
        ,
        .frame_cnt       (frame_cnt),
        .drop_cnt        (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            got.push_back({out_port, out_sop, out_eop, out_word});
        end
    end

    always @(negedge clk) begin
        if (reset_n && drop_pulse) begin
            n_drop++;
        end
    end

    task automatic check(input string tag, input logic [31:0] g,
                         input logic [31:0] e);
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, g, e);
        end
    endtask

    task automatic put(input logic c, input logic [7:0] v);
        ctl  = c;
        data = v;
        @(posedge clk);
        #1;
    endtask

    task automatic hb(input logic [7:0] v);
        put(1'b1, v);
        cur.push_back({1'b1, v});
    endtask

    task automatic db(input logic [7:0] v);
        put(1'b0, v);
        cur.push_back({1'b0, v});
    endtask

    task automatic idle(input int n);
        repeat (n) put(1'b1, 8'h00);
    endtask

    task automatic keep(input logic [1:0] p);
        logic s;
        logic e;
        foreach (cur[i]) begin
            s = (i == 0);
            e = (i == cur.size() - 1);
            exp_q.push_back({p, s, e, cur[i]});
        end
        cur.delete();
    endtask

    task automatic verify(input string tag);
        int n;
        check({tag, " count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check(tag, got[i], exp_q[i]);
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        n_drop    = 0;
        reset_n   = 1'b0;
        ctl       = 1'b1;
        data      = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst valid", out_valid, 0);
        check("rst word", out_word, 9'h100);
        check("rst port", out_port, 0);
        check("rst sop", out_sop, 0);
        check("rst eop", out_eop, 0);
        check("rst drop", drop_pulse, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);

        // write frame, A=1 D=2
        hb(8'h0A); db(8'h41); db(8'h10); db(8'h00); db(8'hAA); db(8'hBB);
        keep(2'd1);
        idle(12);
        verify("t1");

        // read frame A=2 with a 3-cycle stall mid-frame
        hb(8'h41); db(8'h43); db(8'h10); db(8'h20); db(8'h21);
        keep(2'd3);
        ctl  = 1'b1;
        data = 8'h00;
        for (int k = 0; k < 40 && got.size() < 2; k++) begin
            @(posedge clk);
            #1;
        end
        check("t2 start", got.size() >= 2, 1);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t2 hold v", out_valid, 1);
            check("t2 hold w", out_word, 9'h010);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(10);
        verify("t2");

        // bad dest
        d0 = n_drop;
        hb(8'h01); db(8'h50); db(8'h10); db(8'h00);
        cur.delete();
        hb(8'h01); db(8'h40); db(8'h10); db(8'h05);
        keep(2'd0);
        idle(12);
        verify("t3");
        check("t3 drops", n_drop - d0, 1);

        // bad opcode
        d0 = n_drop;
        hb(8'h07); db(8'h41); db(8'h10); db(8'h00);
        cur.delete();
        hb(8'h01); db(8'h42); db(8'h11); db(8'h22);
        keep(2'd2);
        idle(12);
        verify("t4");
        check("t4 drops", n_drop - d0, 1);

        // frame cut by a new header
        d0 = n_drop;
        hb(8'h0A); db(8'h41); db(8'h10);
        cur.delete();
        hb(8'h01); db(8'h41); db(8'h20); db(8'h30);
        keep(2'd1);
        idle(12);
        verify("t5");
        check("t5 drops", n_drop - d0, 1);

        // truncation by idle byte, then write A=1 D=1
        d0 = n_drop;
        hb(8'h01); db(8'h42);
        put(1'b1, 8'h00);
        cur.delete();
        hb(8'h02); db(8'h43); db(8'h10); db(8'h00); db(8'h77);
        keep(2'd3);
        idle(12);
        verify("t5b");
        check("t5b drops", n_drop - d0, 1);

        // descriptor queue full
        d0 = n_drop;
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            hb(8'h01);
            db(8'h40 + 8'(i % 4));
            db(8'h20 + 8'(i));
            db(8'h30 + 8'(i));
            if (i < 8) keep(2'(i % 4));
            else cur.delete();
            idle(2);
        end
        idle(4);
        @(negedge clk);
        check("t6 drops", n_drop - d0, 1);
        check("t6 none out", got.size(), 0);
        check("t6 held v", out_valid, 1);
        check("t6 held w", out_word, 9'h101);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(45);
        verify("t6");

        // reset during output
        out_ready = 1'b0;
        hb(8'h01); db(8'h41); db(8'h10); db(8'h00);
        hb(8'h01); db(8'h41); db(8'h11); db(8'h01);
        cur.delete();
        idle(3);
        out_ready = 1'b1;
        idle(3);
        reset_n = 1'b0;
        got.delete();
        @(negedge clk);
        check("t7 valid", out_valid, 0);
        check("t7 sop", out_sop, 0);
        check("t7 eop", out_eop, 0);
        check("t7 word", out_word, 9'h100);
        check("t7 port", out_port, 0);
        check("t7 drop", drop_pulse, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(10);
        check("t7 empty", got.size(), 0);
        hb(8'h01); db(8'h43); db(8'h55); db(8'h66);
        keep(2'd3);
        idle(12);
        verify("t7 post");
`ifdef NOC_CMD_PARSER_STATS_EN
        check("stat frames", frame_cnt, 16'd1);
        check("stat drops", drop_cnt, 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
